// File: rtl/rgb_pwm_fader.sv
`default_nettype none
// ============================================================================
//  Module      : rgb_pwm_fader
//  Description : Three-channel PWM colour output with immediate or per-period
//                linear fade toward a commanded colour. Optional quadratic
//                gamma on the PWM compare is enabled by RGB_PWM_GAMMA_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module rgb_pwm_fader #(
    parameter int PWM_BITS = 8,
    parameter int PRESCALE = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [PWM_BITS-1:0] cmd_r,
    input  logic [PWM_BITS-1:0] cmd_g,
    input  logic [PWM_BITS-1:0] cmd_b,
    input  logic                cmd_fade,
    output logic                red,
    output logic                green,
    output logic                blue,
    output logic                busy
);

    localparam int                  PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0]     PS_MAX  = PS_W'(PRESCALE - 1);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_APPLY = 2'd1;
    localparam logic [1:0] S_FADE  = 2'd2;

    logic [PS_W-1:0]     r_presc;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic [1:0]          r_state;
    logic [PWM_BITS-1:0] r_lvl_r, r_lvl_g, r_lvl_b;
    logic [PWM_BITS-1:0] r_tgt_r, r_tgt_g, r_tgt_b;
    logic                r_red, r_green, r_blue;

    logic                w_tick;
    logic                w_period_end;
    logic [PWM_BITS-1:0] w_step_r, w_step_g, w_step_b;
    logic                w_fade_done;
    logic [PWM_BITS-1:0] w_duty_r, w_duty_g, w_duty_b;

    function automatic logic [PWM_BITS-1:0] step_toward(
        input logic [PWM_BITS-1:0] lvl,
        input logic [PWM_BITS-1:0] tgt
    );
        if (lvl < tgt)
            return lvl + PWM_BITS'(1);
        else if (lvl > tgt)
            return lvl - PWM_BITS'(1);
        else
            return lvl;
    endfunction

`ifdef RGB_PWM_GAMMA_EN
    // g(x) = x*(x+1) >> PWM_BITS keeps g(0)=0 and g(max)=max exactly.
    function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] lvl);
        logic [2*PWM_BITS-1:0] prod;
        prod = {{PWM_BITS{1'b0}}, lvl} * ({{PWM_BITS{1'b0}}, lvl} + (2*PWM_BITS)'(1));
        return prod[2*PWM_BITS-1:PWM_BITS];
    endfunction

    assign w_duty_r = gamma(r_lvl_r);
    assign w_duty_g = gamma(r_lvl_g);
    assign w_duty_b = gamma(r_lvl_b);
`else
    assign w_duty_r = r_lvl_r;
    assign w_duty_g = r_lvl_g;
    assign w_duty_b = r_lvl_b;
`endif

    assign w_tick       = (r_presc == PS_MAX);
    assign w_period_end = w_tick && (r_pwm_cnt == CNT_MAX);

    assign w_step_r    = step_toward(r_lvl_r, r_tgt_r);
    assign w_step_g    = step_toward(r_lvl_g, r_tgt_g);
    assign w_step_b    = step_toward(r_lvl_b, r_tgt_b);
    assign w_fade_done = (w_step_r == r_tgt_r) && (w_step_g == r_tgt_g) && (w_step_b == r_tgt_b);

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign red       = r_red;
    assign green     = r_green;
    assign blue      = r_blue;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
            r_red     <= 1'b0;
            r_green   <= 1'b0;
            r_blue    <= 1'b0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PS_W'(1);
            if (w_tick)
                r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
            r_red   <= (r_pwm_cnt < w_duty_r);
            r_green <= (r_pwm_cnt < w_duty_g);
            r_blue  <= (r_pwm_cnt < w_duty_b);
        end
    end

    // Levels move only on the last tick of a period so every pulse is whole.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_lvl_r <= '0;
            r_lvl_g <= '0;
            r_lvl_b <= '0;
            r_tgt_r <= '0;
            r_tgt_g <= '0;
            r_tgt_b <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_tgt_r <= cmd_r;
                        r_tgt_g <= cmd_g;
                        r_tgt_b <= cmd_b;
                        r_state <= cmd_fade ? S_FADE : S_APPLY;
                    end
                end
                S_APPLY: begin
                    if (w_period_end) begin
                        r_lvl_r <= r_tgt_r;
                        r_lvl_g <= r_tgt_g;
                        r_lvl_b <= r_tgt_b;
                        r_state <= S_IDLE;
                    end
                end
                S_FADE: begin
                    if (w_period_end) begin
                        r_lvl_r <= w_step_r;
                        r_lvl_g <= w_step_g;
                        r_lvl_b <= w_step_b;
                        if (w_fade_done)
                            r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rgb_pwm_fader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_rgb_pwm_fader
//  Description : Self-checking bench for rgb_pwm_fader (PRESCALE=4, 8-bit).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rgb_pwm_fader;

    localparam int PWM_BITS = 8;
    localparam int PRESCALE = 4;
    localparam int PERIOD   = PRESCALE * (1 << PWM_BITS);

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                cmd_valid = 1'b0;
    logic                cmd_ready;
    logic [PWM_BITS-1:0] cmd_r = '0;
    logic [PWM_BITS-1:0] cmd_g = '0;
    logic [PWM_BITS-1:0] cmd_b = '0;
    logic                cmd_fade = 1'b0;
    logic                red, green, blue, busy;

    rgb_pwm_fader #(.PWM_BITS(PWM_BITS), .PRESCALE(PRESCALE)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_r     (cmd_r),
        .cmd_g     (cmd_g),
        .cmd_b     (cmd_b),
        .cmd_fade  (cmd_fade),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int g;
        int b;
        bit fade;
        int periods;
        bit chk_g;
    } vec_t;

    typedef struct {
        string name;
        int    periods;
        int    hr;
        int    hg;
        int    hb;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Duty in ticks for a linear level, with the optional gamma curve.
    function automatic int duty(input int lvl);
`ifdef RGB_PWM_GAMMA_EN
        return (lvl * (lvl + 1)) / 256;
`else
        return lvl;
`endif
    endfunction

    function automatic int hi(input int lvl);
        return PRESCALE * duty(lvl);
    endfunction

    task automatic send(input int r, input int g, input int b, input bit f);
        int n = 0;
        while (!cmd_ready && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready)
            check("send_ready_timeout", 0, 1);
        cmd_r     = PWM_BITS'(r);
        cmd_g     = PWM_BITS'(g);
        cmd_b     = PWM_BITS'(b);
        cmd_fade  = f;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic push_exp(input string name, input int periods, input int r, input int g, input int b);
        exp_t e;
        e.name    = name;
        e.periods = periods;
        e.hr      = hi(r);
        e.hg      = hi(g);
        e.hb      = hi(b);
        sbq.push_back(e);
    endtask

    task automatic wait_idle(inout int busy_cnt, input int exp_gw, output bit g_ok);
        bit prev = green;
        bit rose = 1'b0;
        int w    = 0;
        g_ok = 1'b1;
        while (busy && busy_cnt < 20000) begin
            busy_cnt++;
            @(negedge clk);
            if (green && !prev) begin
                w    = 1;
                rose = 1'b1;
            end else if (green) begin
                w++;
            end else if (prev && rose && w != exp_gw) begin
                g_ok = 1'b0;
            end
            if (exp_gw == 0 && green)
                g_ok = 1'b0;
            prev = green;
        end
        if (busy)
            check("busy_timeout", 1, 0);
    endtask

    task automatic measure(output int hr, output int hg, output int hb);
        hr = 0; hg = 0; hb = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            hr += int'(red);
            hg += int'(green);
            hb += int'(blue);
        end
    endtask

    task automatic finish_cmd(input int busy_start, input int exp_gw, output bit g_ok);
        int   bc = busy_start;
        int   hr, hg, hb;
        exp_t e;
        wait_idle(bc, exp_gw, g_ok);
        measure(hr, hg, hb);
        e = sbq.pop_front();
        check({e.name, "_periods"}, (bc + PERIOD - 1) / PERIOD, e.periods);
        check({e.name, "_red_hi"},   hr, e.hr);
        check({e.name, "_green_hi"}, hg, e.hg);
        check({e.name, "_blue_hi"},  hb, e.hb);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int   cnt, bc, bhi, np, w;
        bit   prev, g_ok;
        int   widths[3];

        vecs[0] = '{r: 64,  g: 0,   b: 255, fade: 1'b0, periods: 1, chk_g: 1'b0};
        vecs[1] = '{r: 10,  g: 2,   b: 5,   fade: 1'b0, periods: 1, chk_g: 1'b0};
        vecs[2] = '{r: 8,   g: 2,   b: 7,   fade: 1'b1, periods: 2, chk_g: 1'b1};
        vecs[3] = '{r: 8,   g: 2,   b: 7,   fade: 1'b1, periods: 1, chk_g: 1'b0};
        vecs[4] = '{r: 0,   g: 0,   b: 0,   fade: 1'b1, periods: 8, chk_g: 1'b0};
        vecs[5] = '{r: 128, g: 0,   b: 0,   fade: 1'b0, periods: 1, chk_g: 1'b0};
        vecs[6] = '{r: 255, g: 255, b: 0,   fade: 1'b0, periods: 1, chk_g: 1'b0};

        // Reset and idle behaviour
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("reset_outputs", int'({red, green, blue}), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_ready", int'(cmd_ready), 1);
        cnt = 0;
        repeat (2048) begin
            @(negedge clk);
            cnt += int'(red | green | blue | busy);
        end
        check("idle_outputs_high", cnt, 0);

        // Fade up from 0: red pulses grow one tick per period
        send(3, 3, 0, 1'b1);
        bc = 1; bhi = 0; np = 0; w = 0; prev = red;
        widths = '{0, 0, 0};
        repeat (4 * PERIOD + 64) begin
            bc  += int'(busy);
            @(negedge clk);
            bhi += int'(blue);
            if (red) begin
                w++;
            end else if (prev) begin
                if (np < 3) widths[np] = w;
                np++;
                w = 0;
            end
            prev = red;
        end
        check("fadeup_pulse1", widths[0], hi(1));
        check("fadeup_pulse2", widths[1], hi(2));
        check("fadeup_pulse3", widths[2], hi(3));
        check("fadeup_periods", (bc - 1 + PERIOD - 1) / PERIOD, 3);
        check("fadeup_blue_hi", bhi, 0);
        check("fadeup_busy_end", int'(busy), 0);

        // Table of colour commands
        for (int i = 0; i < 7; i++) begin
            send(vecs[i].r, vecs[i].g, vecs[i].b, vecs[i].fade);
            push_exp($sformatf("vec%0d", i), vecs[i].periods, vecs[i].r, vecs[i].g, vecs[i].b);
            finish_cmd(0, hi(vecs[i].g), g_ok);
            if (vecs[i].chk_g)
                check($sformatf("vec%0d_green_steady", i), int'(g_ok), 1);
        end

        // Backpressure: a command offered mid-fade must be ignored
        send(250, 255, 0, 1'b1);
        push_exp("bp", 5, 250, 255, 0);
        bc = 0;
        repeat (200) begin
            bc += int'(busy);
            @(negedge clk);
        end
        cmd_r = '0; cmd_g = '0; cmd_b = '0; cmd_fade = 1'b0;
        cmd_valid = 1'b1;
        cnt = 0;
        repeat (5) begin
            cnt += int'(cmd_ready);
            bc  += int'(busy);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        check("bp_ready_high", cnt, 0);
        finish_cmd(bc, -1, g_ok);

        // Asynchronous reset in the middle of a fade
        send(0, 0, 0, 1'b1);
        repeat (300) @(negedge clk);
        check("midfade_busy", int'(busy), 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("midreset_outputs", int'({red, green, blue}), 0);
        check("midreset_busy", int'(busy), 0);
        check("midreset_ready", int'(cmd_ready), 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (PERIOD) begin
            @(negedge clk);
            cnt += int'(red | green | blue | busy);
        end
        check("post_reset_dark", cnt, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rgb_pwm_fader.md
Name: rgb_pwm_fader

Overview:
- Colour-output stage that turns 8-bit-per-channel colour commands into red/green/blue PWM pin drives.
- Sits beside the LED colour controller, directly ahead of the LED pins; the controller (or any sequencer) issues colour commands over a valid/ready handshake.
- Supports an immediate colour change or a linear fade, one LSB per PWM period, toward the commanded colour.

Parameters:
- PWM_BITS, 8, width of duty levels and of the PWM counter; PWM period = 2^PWM_BITS ticks.
- PRESCALE, 4, clk cycles per PWM tick (>=1); PWM period = PRESCALE * 2^PWM_BITS clk cycles.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  block can accept a command.
- cmd_r  input  PWM_BITS  target red level.
- cmd_g  input  PWM_BITS  target green level.
- cmd_b  input  PWM_BITS  target blue level.
- cmd_fade  input  1  1 = fade to target, 0 = apply at next period boundary.
- red  output  1  red PWM drive, active-high.
- green  output  1  green PWM drive, active-high.
- blue  output  1  blue PWM drive, active-high.
- busy  output  1  high while a command is in progress.

Behaviour:
- Reset (reset=0, async):
  - prescaler, pwm_cnt, levels and targets cleared to 0.
  - FSM enters IDLE.
  - red/green/blue=0, busy=0, cmd_ready=1 (in IDLE).
- Prescaler:
  - counts 0..PRESCALE-1; tick asserted for one cycle when count = PRESCALE-1.
  - PRESCALE=1 gives a tick every cycle.
- pwm_cnt:
  - increments on tick; wraps from 2^PWM_BITS-1 to 0.
  - period_end = tick and pwm_cnt = 2^PWM_BITS-1.
- Channel output:
  - registered; x = (pwm_cnt < level_x), one cycle latency from pwm_cnt.
  - level 0 gives constant low; level 255 gives high 255 of 256 ticks (never 100%).
- Levels change only on period_end, so no glitch or truncated pulse occurs mid-period.
- Handshake:
  - accept when cmd_valid & cmd_ready; cmd_r/g/b and cmd_fade latched that cycle.
  - cmd_ready = (state == IDLE).
  - cmd_valid while not ready is ignored; the data is not sampled.
- FSM states:
  - IDLE: on accept, go to APPLY if cmd_fade=0, else FADE; busy=1 from the next cycle.
  - APPLY: on period_end, level_x <= target_x for all channels, then go to IDLE.
  - FADE: on each period_end, each level_x steps +1 or -1 toward target_x; equal levels hold. Go to IDLE on the period_end where all levels equal their targets after the step.
  - Fade with target equal to the current level: completes on the first period_end.
- Fade duration = max |target_x - level_x| periods; no overshoot, no wrap (a level never crosses 0 or 255).
- busy = (state != IDLE). cmd_ready rises the cycle after the final level update.
- Reset mid-operation: outputs drop to 0 asynchronously and any in-flight command is discarded.
- Arithmetic: unsigned compare only; pwm_cnt and levels are PWM_BITS wide.

Optional Feature:
- Macro: RGB_PWM_GAMMA_EN.
- Defined:
  - each output compares pwm_cnt against g(level) = (level*(level+1)) >> PWM_BITS, computed combinationally with a 2*PWM_BITS-wide product.
  - g(0)=0, g(128)=64, g(255)=255.
  - Applies to all three channels; fade stepping still acts on the linear level.
- Undefined: compare against the linear level directly, and no multiplier is synthesised.

Test Plan:
- Reset checks:
  - Hold reset=0 for 3 cycles, then release → red/green/blue=0, busy=0, cmd_ready=1.
  - Hold idle for 2048 clk → outputs remain 0.
- Immediate colour:
  - Cmd r=64 g=0 b=255 fade=0 (PRESCALE=4) → busy=1 until the next period boundary.
  - Following 1024-clk period: red high 256 clk, green high 0 clk, blue high 1020 clk.
- Fade up:
  - From level 0, cmd r=3 g=3 b=0 fade=1 → red duty 1, 2, 3 ticks in successive periods.
  - busy drops after the 3rd period_end; blue stays 0.
- Fade down with mixed distance:
  - From levels r=10 g=2 b=5, cmd r=8 g=2 b=7 fade=1 → completes after 2 periods, r=8 g=2 b=7.
  - g stays 2 throughout; busy=1 for exactly 2 period_ends.
- Backpressure and mid-fade reset:
  - Assert cmd_valid during FADE → cmd_ready=0 and the command is not taken.
  - Pulse reset=0 mid-fade → outputs 0 immediately, IDLE, cmd_ready=1.
- Gamma (RGB_PWM_GAMMA_EN defined): immediate r=128 → red high 64 ticks (256 clk) per period.
- Gamma (undefined): same command → red high 128 ticks (512 clk) per period.
